lmg_move_fifo: RTL and testbench
================================

Name: lmg_move_fifo

Overview:
- Buffers 152-bit move records from the legal move generator (LMG) until the control block reads them.
- Serialises each record into five 32-bit words so the control block's Avalon-MM slave can return them one read at a time.
- Sits between the LMG output (the lmgFifoOut record stream) and the control block's readdata path.
- Also latches LMG completion status and reports overflow.

Parameters:
- REC_WIDTH, 152: move record width in bits. The word map below is fixed for 152.
- DEPTH, 64: number of records stored. Must be a power of 2.
- ADDR_BITS, 6: log2(DEPTH).
- DATA_WIDTH, 32: width of the word output.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- lmgReset  in  1  synchronous flush from the control block.
- wr_valid  in  1  LMG presents a record this cycle.
- wr_data  in  REC_WIDTH  move record from the LMG.
- wr_ready  out  1  high when count < DEPTH.
- lmgdone  in  1  single-cycle pulse: the LMG has finished generating.
- rd_word_req  in  1  consume the current output word.
- rd_word  out  DATA_WIDTH  current word of the head record.
- rd_word_valid  out  1  high when count != 0.
- count  out  ADDR_BITS+1  number of records stored.
- done_latched  out  1  lmgdone has been seen since the last flush.
- drained  out  1  done_latched && count == 0.
- overflow  out  1  sticky: a push was attempted while full.

Behaviour:
- Reset (async, reset=1): wr_ptr=0, rd_ptr=0, count=0, word_idx=0, done_latched=0, overflow=0.
  - Outputs while in reset: wr_ready=1, rd_word_valid=0, drained=0, rd_word=0.
  - Storage array contents are not reset.
- Flush (lmgReset=1 at a rising edge): same state clear as reset.
  - Has priority over every other input in that cycle; a push, pop or lmgdone in the same cycle is discarded.
- Push: a record is accepted when wr_valid && count < DEPTH.
  - mem[wr_ptr] <= wr_data, wr_ptr increments modulo DEPTH.
- Push while full: the record is dropped, overflow <= 1, and no other state changes.
- Word serialisation of the head record mem[rd_ptr], selected by word_idx (0..4):
  - idx0 = rec[31:0]
  - idx1 = rec[63:32]
  - idx2 = rec[95:64]
  - idx3 = rec[127:96]
  - idx4 = {8'h00, rec[151:128]}
- rd_word is combinational from mem[rd_ptr] and word_idx. It is 0 when count == 0.
- Pop step: occurs when rd_word_req && count != 0.
  - If word_idx < 4: word_idx increments.
  - If word_idx == 4: word_idx <= 0, rd_ptr increments modulo DEPTH, and the record is retired.
- rd_word_req while empty is ignored; word_idx does not change.
- Count update:
  - +1 on accepted push.
  - -1 on retire.
  - Unchanged when both happen in the same cycle.
  - Push and retire in the same cycle are both legal when full. A push at count == DEPTH with a same-cycle retire is still dropped, because wr_ready is evaluated from the pre-edge count.
- Pointer wrap-around: wr_ptr and rd_ptr wrap from DEPTH-1 to 0. Full and empty are distinguished by count only.
- Latency:
  - A record pushed at edge N is visible on rd_word / rd_word_valid after edge N.
  - Pop to next word: the next word is visible after the same edge.
- lmgdone: done_latched <= 1 on a pulse and holds until reset or flush.
  - drained is combinational from done_latched and count.
- Reset asserted mid-record (word_idx != 0): all state clears immediately. A partially read record is lost.

Test Plan:
1. Reset, then push one record 152'h00AABBCC_44444444_33333333_22222222_11111111 -> count=1, rd_word_valid=1. Four rd_word_req pulses read 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444; the fifth word is 32'h00AABBCC. After it, count=0 and rd_word=0.
2. Push 64 records with the record value = index -> wr_ready=0 and count=64. Push a 65th -> dropped, overflow=1, count stays 64. Reading all 320 words returns the indices in order; word0 of record k equals k.
3. Wrap-around: push/retire 100 records while keeping count ≤ 3 -> data is in order throughout the pointer wrap, with no overflow.
4. Simultaneous: with count=2 and word_idx=4, push and rd_word_req in the same cycle -> count stays 2, word_idx=0, and rd_word shows word0 of the next record.
5. Pulse lmgdone with count=1 -> done_latched=1, drained=0. Read 5 words -> drained=1. Pulse lmgReset -> done_latched=0, drained=0.
6. Flush priority: push, rd_word_req and lmgdone asserted in the same cycle as lmgReset with count=3 -> count=0, done_latched=0, word_idx=0. Asserting async reset mid-record (word_idx=2) clears all outputs before the next clk edge.

Source files
------------

// File: rtl/lmg_move_fifo_if.sv
// Bundle of the LMG-side record stream, the control-block word read path and
// the status flags of the move FIFO. The master is the LMG/control side, the
// slave is the FIFO itself.
//
// Handshake rules, both channels:
//   write: a record transfers on a rising edge where wr_valid && wr_ready.
//          wr_valid while !wr_ready is a drop and sets the sticky overflow.
//   read:  a word is consumed on a rising edge where rd_word_req && rd_word_valid.
//          rd_word_req while !rd_word_valid is ignored.
//   Both qualifiers come from the registered state before the edge.
interface lmg_move_fifo_if #(
    parameter int REC_WIDTH  = 152,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 6
);
    logic                  lmgReset;
    logic                  wr_valid;
    logic [REC_WIDTH-1:0]  wr_data;
    logic                  wr_ready;
    logic                  lmgdone;
    logic                  rd_word_req;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  rd_word_valid;
    logic [ADDR_BITS:0]    count;
    logic                  done_latched;
    logic                  drained;
    logic                  overflow;
    // Debug view of the word selector inside the head record (0..4).
    logic [2:0]            dbg_word_idx;

    modport master (
        output lmgReset, wr_valid, wr_data, lmgdone, rd_word_req,
        input  wr_ready, rd_word, rd_word_valid, count, done_latched,
               drained, overflow, dbg_word_idx
    );

    modport slave (
        input  lmgReset, wr_valid, wr_data, lmgdone, rd_word_req,
        output wr_ready, rd_word, rd_word_valid, count, done_latched,
               drained, overflow, dbg_word_idx
    );
endinterface

// File: rtl/lmg_move_fifo.sv
// Move-record FIFO between the legal move generator and the control block.
// Stores up to DEPTH 152-bit records and hands the head record out as five
// 32-bit words, low word first, the last word zero-padded in its top byte.
// Also latches the LMG completion pulse and flags dropped pushes.
module lmg_move_fifo #(
    parameter int REC_WIDTH  = 152,
    parameter int DEPTH      = 64,
    parameter int ADDR_BITS  = 6,
    parameter int DATA_WIDTH = 32
) (
    input logic              clk,
    input logic              reset,
    lmg_move_fifo_if.slave   bus
);

    // Full and empty are told apart by the count alone; the pointers wrap freely.
    localparam logic [ADDR_BITS:0] FULL_COUNT = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [2:0]         LAST_WORD  = 3'd4;

    logic [REC_WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_BITS-1:0]  wr_ptr;
    logic [ADDR_BITS-1:0]  rd_ptr;
    logic [ADDR_BITS:0]    count_q;
    logic [2:0]            word_idx;
    logic                  done_q;
    logic                  overflow_q;

    logic                  full;
    logic                  empty;
    logic                  push_ok;
    logic                  push_drop;
    logic                  word_step;
    logic                  retire;
    logic [REC_WIDTH-1:0]  head;
    logic [DATA_WIDTH-1:0] word_sel;

    // Qualifiers derived from the pre-edge count, so a push at full is dropped
    // even if the head record retires in the same cycle.
    always_comb begin
        full      = (count_q == FULL_COUNT);
        empty     = (count_q == '0);
        push_ok   = bus.wr_valid && !full;
        push_drop = bus.wr_valid && full;
        word_step = bus.rd_word_req && !empty;
        retire    = word_step && (word_idx == LAST_WORD);
    end

    // Record storage; deliberately not reset, only the pointers define validity.
    always_ff @(posedge clk) begin
        if (!reset && !bus.lmgReset && push_ok) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    // Write pointer: advances on every accepted push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
        end else if (bus.lmgReset) begin
            wr_ptr <= '0;
        end else if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
        end
    end

    // Read side: word selector walks 0..4, the fifth consumed word retires the record.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            word_idx <= '0;
        end else if (bus.lmgReset) begin
            rd_ptr   <= '0;
            word_idx <= '0;
        end else if (word_step) begin
            if (word_idx == LAST_WORD) begin
                word_idx <= '0;
                rd_ptr   <= rd_ptr + 1'b1;
            end else begin
                word_idx <= word_idx + 3'd1;
            end
        end
    end

    // Occupancy: push and retire in the same cycle cancel out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (bus.lmgReset) begin
            count_q <= '0;
        end else begin
            case ({push_ok, retire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky status: completion pulse and dropped-push flag, cleared only by reset or flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else if (bus.lmgReset) begin
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (bus.lmgdone) begin
                done_q <= 1'b1;
            end
            if (push_drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Word mux over the head record; forced to zero while the FIFO is empty.
    always_comb begin
        head     = mem[rd_ptr];
        word_sel = '0;
        if (!empty) begin
            case (word_idx)
                3'd0:    word_sel = head[31:0];
                3'd1:    word_sel = head[63:32];
                3'd2:    word_sel = head[95:64];
                3'd3:    word_sel = head[127:96];
                3'd4:    word_sel = {8'h00, head[151:128]};
                default: word_sel = '0;
            endcase
        end
    end

    // Output drive.
    always_comb begin
        bus.wr_ready      = !full;
        bus.rd_word       = word_sel;
        bus.rd_word_valid = !empty;
        bus.count         = count_q;
        bus.done_latched  = done_q;
        bus.drained       = done_q && empty;
        bus.overflow      = overflow_q;
        bus.dbg_word_idx  = word_idx;
    end

endmodule

// File: tb/tb_lmg_move_fifo.sv
// Self-checking bench for lmg_move_fifo. A queue of whole records plus a word
// index forms the reference model; expected words are sliced out of the head
// record with a shift.
module tb_lmg_move_fifo;

    logic clk;
    logic reset;

    lmg_move_fifo_if bus ();

    lmg_move_fifo dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [151:0] exp_q[$];
    int           m_idx;
    logic         m_done;
    logic         m_ovf;

    int n_checks;
    int n_errors;

    function automatic logic [31:0] exp_word();
        logic [151:0] r;
        if (exp_q.size() == 0) return 32'h0;
        r = exp_q[0] >> (32 * m_idx);
        return r[31:0];
    endfunction

    function automatic logic [151:0] rand_rec();
        logic [151:0] r;
        for (int i = 0; i < 4; i++) r[32*i +: 32] = $urandom;
        r[151:128] = 24'($urandom);
        return r;
    endfunction

    task automatic model_edge(input logic wv, input logic [151:0] wd,
                              input logic req, input logic dn, input logic fl);
        int pre;
        if (fl) begin
            exp_q.delete();
            m_idx  = 0;
            m_done = 1'b0;
            m_ovf  = 1'b0;
            return;
        end
        pre = exp_q.size();
        if (req && pre != 0) begin
            if (m_idx == 4) begin
                m_idx = 0;
                void'(exp_q.pop_front());
            end else begin
                m_idx++;
            end
        end
        if (wv) begin
            if (pre < 64) exp_q.push_back(wd);
            else m_ovf = 1'b1;
        end
        if (dn) m_done = 1'b1;
    endtask

    // ---------------- driver ----------------
    // One clock cycle with the given inputs; returns #1 after the edge.
    task automatic step(input logic wv, input logic [151:0] wd,
                        input logic req, input logic dn, input logic fl);
        bus.wr_valid    = wv;
        bus.wr_data     = wd;
        bus.rd_word_req = req;
        bus.lmgdone     = dn;
        bus.lmgReset    = fl;
        model_edge(wv, wd, req, dn, fl);
        @(posedge clk);
        #1;
        bus.wr_valid    = 1'b0;
        bus.rd_word_req = 1'b0;
        bus.lmgdone     = 1'b0;
        bus.lmgReset    = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #3;
        n_checks++;
        if (bus.wr_ready !== 1'b1 || bus.rd_word_valid !== 1'b0 || bus.drained !== 1'b0 ||
            bus.rd_word !== 32'h0 || bus.count !== 7'd0 || bus.overflow !== 1'b0 ||
            bus.done_latched !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: ready=%b valid=%b drained=%b word=%h count=%0d ovf=%b done=%b required 1 0 0 0 0 0 0",
                     bus.wr_ready, bus.rd_word_valid, bus.drained, bus.rd_word,
                     bus.count, bus.overflow, bus.done_latched);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        step(0, '0, 0, 0, 0);
    endtask

    task automatic test_single_record();
        logic [151:0] rec;
        logic [31:0]  words [5];
        rec = 152'hAABBCC_44444444_33333333_22222222_11111111;
        words[0] = 32'h11111111; words[1] = 32'h22222222; words[2] = 32'h33333333;
        words[3] = 32'h44444444; words[4] = 32'h00AABBCC;
        step(1, rec, 0, 0, 0);
        n_checks++;
        if (bus.count !== 7'd1 || bus.rd_word_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL single_push: count=%0d valid=%b required 1 1", bus.count, bus.rd_word_valid);
        end
        for (int w = 0; w < 5; w++) begin
            n_checks++;
            if (bus.rd_word !== words[w]) begin
                n_errors++;
                $display("FAIL single_word%0d: got %h required %h", w, bus.rd_word, words[w]);
            end
            step(0, '0, 1, 0, 0);
        end
        n_checks++;
        if (bus.count !== 7'd0 || bus.rd_word !== 32'h0 || bus.rd_word_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL single_empty: count=%0d word=%h valid=%b required 0 0 0",
                     bus.count, bus.rd_word, bus.rd_word_valid);
        end
    endtask

    task automatic test_fill_overflow();
        step(0, '0, 0, 0, 1);
        for (int k = 0; k < 64; k++) step(1, 152'(k), 0, 0, 0);
        n_checks++;
        if (bus.wr_ready !== 1'b0 || bus.count !== 7'd64 || bus.overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL fill_full: ready=%b count=%0d ovf=%b required 0 64 0",
                     bus.wr_ready, bus.count, bus.overflow);
        end
        step(1, rand_rec(), 0, 0, 0);
        n_checks++;
        if (bus.overflow !== 1'b1 || bus.count !== 7'd64) begin
            n_errors++;
            $display("FAIL fill_drop: ovf=%b count=%0d required 1 64", bus.overflow, bus.count);
        end
        // Walk record 0 to its last word, then push on the retiring edge while full.
        for (int w = 0; w < 4; w++) step(0, '0, 1, 0, 0);
        step(1, rand_rec(), 1, 0, 0);
        n_checks++;
        if (bus.count !== 7'(exp_q.size()) || bus.overflow !== m_ovf) begin
            n_errors++;
            $display("FAIL full_push_retire: count=%0d ovf=%b required %0d %b",
                     bus.count, bus.overflow, exp_q.size(), m_ovf);
        end
        for (int k = 1; k < 64; k++) begin
            n_checks++;
            if (bus.rd_word !== 32'(k)) begin
                n_errors++;
                $display("FAIL fill_index: record %0d word0 got %h required %h", k, bus.rd_word, 32'(k));
            end
            for (int w = 0; w < 5; w++) begin
                n_checks++;
                if (bus.rd_word !== exp_word()) begin
                    n_errors++;
                    $display("FAIL fill_word: record %0d word %0d got %h required %h",
                             k, w, bus.rd_word, exp_word());
                end
                step(0, '0, 1, 0, 0);
            end
        end
        n_checks++;
        if (bus.count !== 7'd0 || bus.wr_ready !== 1'b1 || bus.overflow !== 1'b1) begin
            n_errors++;
            $display("FAIL fill_drained: count=%0d ready=%b ovf=%b required 0 1 1",
                     bus.count, bus.wr_ready, bus.overflow);
        end
    endtask

    task automatic test_wrap();
        int pushed;
        int cycles;
        logic wv;
        logic req;
        pushed = 0;
        cycles = 0;
        step(0, '0, 0, 0, 1);
        while ((pushed < 100 || exp_q.size() != 0) && cycles < 5000) begin
            wv  = (pushed < 100) && (exp_q.size() < 3) && ($urandom_range(0, 3) != 0);
            req = ($urandom_range(0, 3) != 0);
            if (wv) pushed++;
            step(wv, rand_rec(), req, 0, 0);
            cycles++;
            n_checks++;
            if (bus.rd_word !== exp_word() || bus.count !== 7'(exp_q.size()) ||
                bus.overflow !== 1'b0 || bus.rd_word_valid !== (exp_q.size() != 0)) begin
                n_errors++;
                $display("FAIL wrap: cycle %0d word=%h count=%0d ovf=%b required word=%h count=%0d ovf=0",
                         cycles, bus.rd_word, bus.count, bus.overflow, exp_word(), exp_q.size());
            end
        end
        n_checks++;
        if (cycles >= 5000) begin
            n_errors++;
            $display("FAIL wrap_budget: cycles=%0d required < 5000", cycles);
        end
    endtask

    task automatic test_back_to_back();
        logic [151:0] r0;
        logic [151:0] r1;
        logic [151:0] r2;
        r0 = rand_rec(); r1 = rand_rec(); r2 = rand_rec();
        step(0, '0, 0, 0, 1);
        step(1, r0, 0, 0, 0);
        step(1, r1, 0, 0, 0);
        for (int w = 0; w < 4; w++) step(0, '0, 1, 0, 0);
        n_checks++;
        if (bus.dbg_word_idx !== 3'd4 || bus.rd_word !== {8'h00, r0[151:128]}) begin
            n_errors++;
            $display("FAIL b2b_setup: idx=%0d word=%h required 4 %h",
                     bus.dbg_word_idx, bus.rd_word, {8'h00, r0[151:128]});
        end
        step(1, r2, 1, 0, 0);
        n_checks++;
        if (bus.count !== 7'd2 || bus.dbg_word_idx !== 3'd0 || bus.rd_word !== r1[31:0] ||
            bus.rd_word !== exp_word()) begin
            n_errors++;
            $display("FAIL b2b_push_retire: count=%0d idx=%0d word=%h required 2 0 %h",
                     bus.count, bus.dbg_word_idx, bus.rd_word, r1[31:0]);
        end
    endtask

    task automatic test_done();
        step(0, '0, 0, 0, 1);
        step(1, rand_rec(), 0, 0, 0);
        step(0, '0, 0, 1, 0);
        n_checks++;
        if (bus.done_latched !== 1'b1 || bus.drained !== 1'b0) begin
            n_errors++;
            $display("FAIL done_pending: done=%b drained=%b required 1 0", bus.done_latched, bus.drained);
        end
        for (int w = 0; w < 5; w++) step(0, '0, 1, 0, 0);
        n_checks++;
        if (bus.drained !== (m_done && exp_q.size() == 0) || bus.drained !== 1'b1) begin
            n_errors++;
            $display("FAIL done_drained: drained=%b required 1", bus.drained);
        end
        step(0, '0, 0, 0, 1);
        n_checks++;
        if (bus.done_latched !== 1'b0 || bus.drained !== 1'b0) begin
            n_errors++;
            $display("FAIL done_flush: done=%b drained=%b required 0 0", bus.done_latched, bus.drained);
        end
    endtask

    task automatic test_flush_priority();
        step(0, '0, 0, 0, 1);
        for (int k = 0; k < 3; k++) step(1, rand_rec(), 0, 0, 0);
        step(0, '0, 1, 0, 0);
        step(1, rand_rec(), 1, 1, 1);
        n_checks++;
        if (bus.count !== 7'd0 || bus.done_latched !== 1'b0 || bus.dbg_word_idx !== 3'd0 ||
            bus.rd_word_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_priority: count=%0d done=%b idx=%0d valid=%b required 0 0 0 0",
                     bus.count, bus.done_latched, bus.dbg_word_idx, bus.rd_word_valid);
        end
        // Async reset in the middle of a record, checked before the next edge.
        step(1, rand_rec(), 0, 1, 0);
        step(1, rand_rec(), 1, 0, 0);
        step(0, '0, 1, 0, 0);
        n_checks++;
        if (bus.dbg_word_idx !== 3'd2 || bus.count !== 7'd2 || bus.rd_word !== exp_word()) begin
            n_errors++;
            $display("FAIL async_setup: idx=%0d count=%0d word=%h required 2 2 %h",
                     bus.dbg_word_idx, bus.count, bus.rd_word, exp_word());
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.count !== 7'd0 || bus.dbg_word_idx !== 3'd0 || bus.rd_word !== 32'h0 ||
            bus.rd_word_valid !== 1'b0 || bus.done_latched !== 1'b0 || bus.drained !== 1'b0 ||
            bus.wr_ready !== 1'b1 || bus.overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: count=%0d idx=%0d word=%h valid=%b done=%b drained=%b ready=%b ovf=%b required 0 0 0 0 0 0 1 0",
                     bus.count, bus.dbg_word_idx, bus.rd_word, bus.rd_word_valid,
                     bus.done_latched, bus.drained, bus.wr_ready, bus.overflow);
        end
        model_edge(0, '0, 0, 0, 1);
        #1;
        reset = 1'b0;
        step(0, '0, 0, 0, 0);
        n_checks++;
        if (bus.count !== 7'd0 || bus.rd_word_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL after_reset: count=%0d valid=%b required 0 0", bus.count, bus.rd_word_valid);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks        = 0;
        n_errors        = 0;
        m_idx           = 0;
        m_done          = 1'b0;
        m_ovf           = 1'b0;
        reset           = 1'b1;
        bus.lmgReset    = 1'b0;
        bus.wr_valid    = 1'b0;
        bus.wr_data     = '0;
        bus.lmgdone     = 1'b0;
        bus.rd_word_req = 1'b0;

        test_reset();
        test_single_record();
        test_fill_overflow();
        test_wrap();
        test_back_to_back();
        test_done();
        test_flush_priority();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
